// File: rtl/hero_ctrl.sv
// hero_ctrl: five-glyph hero sequencer - button-timed jump/duck actions, saturating
// score, per-slot pose codes and the one-hot digit scan for the shared segment bus.
module hero_ctrl #(
    parameter int TICK_DIV   = 4,
    parameter int SCAN_DIV   = 3,
    parameter int JUMP_TICKS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [1:0] sel_u,
    output logic [1:0] sel_i,
    output logic [1:0] sel_p,
    output logic [1:0] sel_f,
    output logic [1:0] sel_e,
    output logic [4:0] dig_en,
    output logic [2:0] hero_pos,
    output logic       busy,
    output logic [7:0] score
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int AW = $clog2(JUMP_TICKS + 1);

    // State encoding doubles as the pose code driven onto the hero slot.
    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    state_t        state;
    logic [2:0]    up_sync, dn_sync;
    logic [TW-1:0] tick_cnt;
    logic [AW-1:0] act_cnt;
    logic [SW-1:0] scan_cnt;
    logic          up_pulse, dn_pulse, tick, scan_wrap;
    logic [1:0]    pose;

    // Bit 0 = s1, bit 1 = s2, bit 2 = s2_d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_sync <= '0;
            dn_sync <= '0;
        end else begin
            up_sync <= {up_sync[1:0], btn_up};
            dn_sync <= {dn_sync[1:0], btn_down};
        end
    end

    assign up_pulse  = up_sync[1] & ~up_sync[2];
    assign dn_pulse  = dn_sync[1] & ~dn_sync[2];
    assign tick      = tick_cnt == TW'(TICK_DIV - 1);
    assign scan_wrap = scan_cnt == SW'(SCAN_DIV - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            act_cnt  <= '0;
            hero_pos <= '0;
            score    <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            if (state == IDLE) begin
                if (up_pulse || dn_pulse) begin
                    state    <= up_pulse ? UP : DOWN;
                    act_cnt  <= AW'(JUMP_TICKS);
                    tick_cnt <= '0;
                end
            end else if (tick) begin
                act_cnt <= act_cnt - 1'b1;
                if (act_cnt == AW'(1)) begin
                    state    <= IDLE;
                    hero_pos <= hero_pos == 3'd4 ? 3'd0 : hero_pos + 3'd1;
                    score    <= score == 8'hFF ? score : score + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_en   <= 5'b00001;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
            if (scan_wrap)
                dig_en <= {dig_en[3:0], dig_en[4]};
        end
    end

    assign pose  = state;
    assign busy  = state != IDLE;
    assign sel_u = hero_pos == 3'd0 ? pose : 2'd0;
    assign sel_i = hero_pos == 3'd1 ? pose : 2'd0;
    assign sel_p = hero_pos == 3'd2 ? pose : 2'd0;
    assign sel_f = hero_pos == 3'd3 ? pose : 2'd0;
    assign sel_e = hero_pos == 3'd4 ? pose : 2'd0;
endmodule

// File: tb/tb_hero_ctrl.sv
// tb_hero_ctrl: stimulus queues the expected outcome of each action; a monitor
// retires one entry every time busy falls and compares pose, slot, length and score.
module tb_hero_ctrl;
    logic       clk = 0, rst_n = 0, btn_up = 0, btn_down = 0;
    logic [1:0] sel_u, sel_i, sel_p, sel_f, sel_e;
    logic [4:0] dig_en;
    logic [2:0] hero_pos;
    logic       busy;
    logic [7:0] score;
    int         checks = 0, passes = 0;

    typedef struct {
        int code;
        int slot;
        int len;
        int pos;
        int score;
    } exp_t;
    exp_t q[$];

    hero_ctrl #(.TICK_DIV(4), .SCAN_DIV(3), .JUMP_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
        .sel_u(sel_u), .sel_i(sel_i), .sel_p(sel_p), .sel_f(sel_f), .sel_e(sel_e),
        .dig_en(dig_en), .hero_pos(hero_pos), .busy(busy), .score(score)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic expect_act(input int code, input int slot, input int pos, input int sc);
        exp_t e;
        e.code  = code;
        e.slot  = slot;
        e.len   = 8;
        e.pos   = pos;
        e.score = sc;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(1);
        rst_n = 0;
        step(3);
        rst_n = 1;
        step(2);
    endtask

    task automatic press(input bit up);
        if (up) btn_up = 1;
        else btn_down = 1;
        step(2);
        btn_up = 0;
        btn_down = 0;
        step(2);
    endtask

    task automatic settle();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("settle_drain", q.size(), 0);
        q.delete();
        step(1);
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy", int'(busy), 1);
    endtask

    initial begin : monitor
        bit         in_act;
        int         len, a_code, a_slot, a_nz;
        logic [1:0] sv [5];
        exp_t       e;
        in_act = 0;
        len = 0; a_code = 0; a_slot = 0; a_nz = 0;
        forever begin
            @(negedge clk);
            sv[0] = sel_u; sv[1] = sel_i; sv[2] = sel_p; sv[3] = sel_f; sv[4] = sel_e;
            if (!rst_n) in_act = 0;
            else if (busy && !in_act) begin
                in_act = 1;
                len = 1; a_nz = 0; a_code = 0; a_slot = 0;
                for (int j = 0; j < 5; j++)
                    if (sv[j] != 2'd0) begin
                        a_nz++;
                        a_code = int'(sv[j]);
                        a_slot = j;
                    end
            end else if (busy) len++;
            else if (in_act) begin
                in_act = 0;
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_action: slot %0d code %0d, expected no action", a_slot, a_code);
                end else begin
                    e = q.pop_front();
                    chk("act_slots", a_nz, 1);
                    chk("act_code", a_code, e.code);
                    chk("act_slot", a_slot, e.slot);
                    chk("act_len", len, e.len);
                    chk("act_pos", int'(hero_pos), e.pos);
                    chk("act_score", int'(score), e.score);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values and idle digit scan
        step(3);
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_score", int'(score), 0);
        chk("rst_pos", int'(hero_pos), 0);
        chk("rst_dig", int'(dig_en), 1);
        chk("rst_sel", int'({sel_u, sel_i, sel_p, sel_f, sel_e}), 0);
        step(1);
        rst_n = 1;
        for (int n = 0; n <= 20; n++) begin
            @(negedge clk);
            chk("scan", int'(dig_en), 1 << ((n / 3) % 5));
        end
        chk("idle_busy", int'(busy), 0);
        chk("idle_score", int'(score), 0);
        chk("idle_sel", int'({sel_u, sel_i, sel_p, sel_f, sel_e}), 0);

        // Up pulse of 3 cycles, with press latency checked edge by edge
        step(1);
        expect_act(1, 0, 1, 1);
        btn_up = 1;
        @(posedge clk);
        @(negedge clk);
        chk("lat_k", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_k1", int'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_k2_busy", int'(busy), 1);
        chk("lat_k2_sel_u", int'(sel_u), 1);
        btn_up = 0;
        settle();
        chk("up_pos", int'(hero_pos), 1);

        // Held down button: one action only
        do_reset();
        expect_act(2, 0, 1, 1);
        btn_down = 1;
        step(30);
        btn_down = 0;
        settle();
        chk("hold_score", int'(score), 1);

        // Simultaneous rise: up wins; a down press during UP is dropped
        do_reset();
        expect_act(1, 0, 1, 1);
        btn_up = 1;
        btn_down = 1;
        step(3);
        btn_up = 0;
        btn_down = 0;
        step(1);
        btn_down = 1;
        step(2);
        btn_down = 0;
        settle();
        step(12);
        chk("both_score", int'(score), 1);

        // Walk the hero across all slots, then run to score saturation
        do_reset();
        for (int i = 0; i < 260; i++) begin
            expect_act(1, i % 5, (i + 1) % 5, (i + 1 > 255) ? 255 : i + 1);
            press(1);
            settle();
            if (i == 4) begin
                chk("wrap_pos", int'(hero_pos), 0);
                chk("wrap_score", int'(score), 5);
            end
        end
        chk("sat_score", int'(score), 255);
        chk("sat_pos", int'(hero_pos), 0);

        // Asynchronous reset four cycles into an action
        do_reset();
        expect_act(1, 0, 1, 1);
        press(1);
        settle();
        btn_up = 1;
        wait_busy();
        btn_up = 0;
        step(4);
        chk("pre_abort_sel_i", int'(sel_i), 1);
        rst_n = 0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_pos", int'(hero_pos), 0);
        chk("abort_score", int'(score), 0);
        chk("abort_sel", int'({sel_u, sel_i, sel_p, sel_f, sel_e}), 0);
        chk("abort_dig", int'(dig_en), 1);
        step(2);
        rst_n = 1;
        step(2);
        expect_act(1, 0, 1, 1);
        press(1);
        settle();
        chk("resume_score", int'(score), 1);

        chk("final_queue", q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
